// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal arithmetic unit: FSM states, BCD constants
// and digit legality check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BCD_MAX_DIGIT = 9;
    localparam int BCD_RADIX     = 10;

    function automatic logic is_bcd_digit(input logic [3:0] digit);
        return digit <= 4'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction with borrow: d = a - b - bin, folded back into
// 0..9 by adding the radix whenever the raw difference goes negative.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic signed [4:0] raw;
    logic signed [4:0] adj;

    always_comb begin
        raw  = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
        adj  = raw + $signed(5'(BCD_RADIX));
        bout = raw < 0;
        d    = bout ? adj[3:0] : raw[3:0];
    end

endmodule

// File: rtl/bcd_sub_seq.sv
// Digit-serial |A - B| for packed BCD operands, LSD first. A final borrow
// triggers a second digit-serial pass that ten's-complements the result.
module bcd_sub_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_a,
    input  logic [4*DIGITS-1:0] bcd_b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_diff,
    output logic                neg,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_t           state;
    state_t           state_next;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     diff_sh;
    logic [W-1:0]     diff_shifted;
    logic [CNT_W-1:0] idx;
    logic             borrow;
    logic             bad;
    logic             neg_run;
    logic             in_bad;
    logic             last;

    logic [3:0]       sub_a;
    logic [3:0]       sub_b;
    logic [3:0]       sub_d;
    logic             sub_bout;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(bcd_a[4*i +: 4]) || !is_bcd_digit(bcd_b[4*i +: 4]))
                in_bad = 1'b1;
        end
    end

    // NEG reuses the same digit slice as 0 - diff[i] - borrow.
    always_comb begin
        sub_a = (state == NEG) ? 4'd0 : a_sh[3:0];
        sub_b = (state == NEG) ? diff_sh[3:0] : b_sh[3:0];
    end

    bcd_digit_sub u_digit (
        .a    (sub_a),
        .b    (sub_b),
        .bin  (borrow),
        .d    (sub_d),
        .bout (sub_bout)
    );

    // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
    assign diff_shifted = (diff_sh >> 4) | (W'(sub_d) << (W - 4));
    assign last         = (idx == LAST);
    assign busy         = (state == SUB) || (state == NEG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SUB;
            SUB: begin
                if (bad)       state_next = DONE;
                else if (last) state_next = sub_bout ? NEG : DONE;
            end
            NEG:  if (last) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            idx      <= '0;
            borrow   <= 1'b0;
            bad      <= 1'b0;
            neg_run  <= 1'b0;
            done     <= 1'b0;
            bcd_diff <= '0;
            neg      <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= bcd_a;
                        b_sh     <= bcd_b;
                        diff_sh  <= '0;
                        idx      <= '0;
                        borrow   <= 1'b0;
                        bad      <= in_bad;
                        neg_run  <= 1'b0;
                        bcd_diff <= '0;
                        neg      <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                SUB: begin
                    if (!bad) begin
                        diff_sh <= diff_shifted;
                        a_sh    <= a_sh >> 4;
                        b_sh    <= b_sh >> 4;
                        if (last) begin
                            idx     <= '0;
                            borrow  <= 1'b0;
                            neg_run <= sub_bout;
                        end else begin
                            idx    <= idx + 1'b1;
                            borrow <= sub_bout;
                        end
                    end
                end
                NEG: begin
                    diff_sh <= diff_shifted;
                    borrow  <= sub_bout;
                    idx     <= last ? '0 : idx + 1'b1;
                end
                DONE: begin
                    bcd_diff <= bad ? '0 : diff_sh;
                    neg      <= neg_run && !bad;
                    err      <= bad;
                end
                default: ;
            endcase
        end
    end

endmodule
